// File: rtl/branch_resolve.sv
// branch_resolve: resolves conditional branches in the EX stage.
// A taken branch produces a one-cycle redirect pulse carrying the target,
// and holds flush for FLUSH_CYCLES cycles, or longer while stall is high.
// Two saturating statistics counters track resolved and taken branches.
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             cmp_s,
    input  logic [31:0]      ex_pc_plus4,
    input  logic [31:0]      ex_offset,
    input  logic             stall,
    input  logic             clr_cnt,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Loaded on a taken branch. The redirect cycle counts as the first flush cycle.
    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state_r;
    logic [2:0]  fcnt_r;
    logic        accept_s;
    logic [31:0] target_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // A branch is accepted only in IDLE and never while the pipeline is held;
    // the target is the word offset scaled to bytes, and it wraps at 2^32.
    always_comb begin
        accept_s = 1'b0;
        target_s = ex_pc_plus4 + (ex_offset << 2);
        if ((state_r == IDLE) && ex_valid && ex_branch && !stall) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Resolution FSM together with its registered redirect and flush outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            fcnt_r      <= 3'd0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
            flush       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && cmp_s) begin
                        state_r     <= FLUSH;
                        fcnt_r      <= FCNT_INIT;
                        redirect    <= 1'b1;
                        redirect_pc <= target_s;
                        flush       <= 1'b1;
                    end else begin
                        redirect <= 1'b0;
                        flush    <= 1'b0;
                    end
                end
                FLUSH: begin
                    // The redirect pulse always ends after one cycle, even under stall.
                    redirect <= 1'b0;
                    if (!stall && (fcnt_r == 3'd0)) begin
                        state_r <= IDLE;
                        flush   <= 1'b0;
                    end else if (!stall) begin
                        fcnt_r <= fcnt_r - 3'd1;
                        flush  <= 1'b1;
                    end else begin
                        flush  <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    fcnt_r   <= 3'd0;
                    redirect <= 1'b0;
                    flush    <= 1'b0;
                end
            endcase
        end
    end

    // Statistics counters; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (clr_cnt) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else if (accept_s) begin
            br_cnt <= sat_inc(br_cnt);
            if (cmp_s) begin
                taken_cnt <= sat_inc(taken_cnt);
            end else begin
                taken_cnt <= taken_cnt;
            end
        end else begin
            br_cnt    <= br_cnt;
            taken_cnt <= taken_cnt;
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed vectors with hand-computed
// expectations. The stimulus pushes expected redirect targets and flush
// lengths into queues. A negedge monitor pops each expectation and compares it.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_branch = 1'b0;
    logic        cmp_s = 1'b0;
    logic [31:0] ex_pc_plus4 = 32'd0;
    logic [31:0] ex_offset = 32'd0;
    logic        stall = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [3:0]  br_cnt;
    logic [3:0]  taken_cnt;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_pc_q[$];
    int          exp_fl_q[$];
    int          fl_run = 0;

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_branch(ex_branch),
        .cmp_s(cmp_s), .ex_pc_plus4(ex_pc_plus4), .ex_offset(ex_offset),
        .stall(stall), .clr_cnt(clr_cnt), .redirect(redirect),
        .redirect_pc(redirect_pc), .flush(flush), .br_cnt(br_cnt),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string name, input logic [3:0] eb, input logic [3:0] et);
        chk({name, "_br_cnt"}, {28'd0, br_cnt}, {28'd0, eb});
        chk({name, "_taken_cnt"}, {28'd0, taken_cnt}, {28'd0, et});
    endtask

    // Present a branch for one accept edge, queueing expectations if it is taken.
    task automatic issue(input logic [31:0] pc, input logic [31:0] off, input logic tk,
                         input logic [31:0] exp_pc, input int exp_fl);
        ex_pc_plus4 = pc;
        ex_offset   = off;
        cmp_s       = tk;
        ex_valid    = 1'b1;
        ex_branch   = 1'b1;
        if (tk) begin
            exp_pc_q.push_back(exp_pc);
            exp_fl_q.push_back(exp_fl);
        end
        step();
        ex_valid  = 1'b0;
        ex_branch = 1'b0;
    endtask

    // Monitor: checks each redirect target and the length of each flush episode.
    always @(negedge clk) begin
        if (redirect) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_redirect: got pc %h expected no redirect at %0t", redirect_pc, $time);
            end else begin
                chk("redirect_pc", redirect_pc, exp_pc_q.pop_front());
            end
        end
        if (flush) begin
            fl_run++;
        end else if (fl_run > 0) begin
            if (exp_fl_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flush: got %0d cycles expected none at %0t", fl_run, $time);
            end else begin
                chk("flush_len", fl_run, exp_fl_q.pop_front());
            end
            fl_run = 0;
        end
    end

    initial begin
        // Reset values appear asynchronously, before any clock edge.
        #1 reset = 1'b1;
        #1;
        chk("rst_redirect", {31'd0, redirect}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk_cnt("rst", 4'd0, 4'd0);
        #10 reset = 1'b0;

        // Taken branch on the first edge after reset: 0x00400010 + 4*4.
        issue(32'h0040_0010, 32'h0000_0004, 1'b1, 32'h0040_0020, 2);
        chk("taken_redirect_next", {31'd0, redirect}, 32'd1);
        chk("taken_flush_next", {31'd0, flush}, 32'd1);
        repeat (3) step();
        chk_cnt("taken", 4'd1, 4'd1);

        // Not-taken branch: no redirect and no flush.
        issue(32'h0040_0010, 32'hFFFF_FFFC, 1'b0, 32'd0, 0);
        chk("nt_redirect", {31'd0, redirect}, 32'd0);
        chk("nt_flush", {31'd0, flush}, 32'd0);
        repeat (2) step();
        chk_cnt("nt", 4'd2, 4'd1);

        // Target wraps modulo 2^32: 0xFFFFFFF0 + 0x20.
        issue(32'hFFFF_FFF0, 32'h0000_0008, 1'b1, 32'h0000_0010, 2);
        repeat (3) step();
        chk_cnt("wrap", 4'd3, 4'd2);

        // A non-branch, and a branch without ex_valid, change nothing.
        ex_valid = 1'b1; ex_branch = 1'b0; cmp_s = 1'b1;
        step();
        ex_valid = 1'b0; ex_branch = 1'b1;
        step();
        ex_branch = 1'b0;
        step();
        chk_cnt("nonbranch", 4'd3, 4'd2);

        // Branch held under stall in IDLE; it is accepted once stall drops.
        stall = 1'b1;
        ex_pc_plus4 = 32'h0000_0100; ex_offset = 32'h0000_0010; cmp_s = 1'b1;
        ex_valid = 1'b1; ex_branch = 1'b1;
        step();
        step();
        chk("idle_stall_redirect", {31'd0, redirect}, 32'd0);
        chk_cnt("idle_stall", 4'd3, 4'd2);
        stall = 1'b0;
        exp_pc_q.push_back(32'h0000_0140);
        exp_fl_q.push_back(2);
        step();
        ex_valid = 1'b0; ex_branch = 1'b0;
        repeat (3) step();
        chk_cnt("after_stall", 4'd4, 4'd3);

        // Stall for 3 cycles in FLUSH with the branch held on the inputs.
        issue(32'h0000_0200, 32'h0000_0001, 1'b1, 32'h0000_0204, 5);
        ex_valid = 1'b1; ex_branch = 1'b1;
        stall = 1'b1;
        repeat (3) step();
        chk("flush_during_stall", {31'd0, flush}, 32'd1);
        stall = 1'b0;
        repeat (2) step();
        ex_valid = 1'b0; ex_branch = 1'b0;
        repeat (2) step();
        chk_cnt("flush_stall", 4'd5, 4'd4);
        chk("pc_hold", redirect_pc, 32'h0000_0204);

        // A clear on its own.
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        chk_cnt("clr", 4'd0, 4'd0);

        // 17 taken branches saturate both counters at 0xF.
        for (int i = 0; i < 17; i++) begin
            issue(32'h0000_1000, 32'h0000_0001, 1'b1, 32'h0000_1004, 2);
            repeat (2) step();
        end
        chk_cnt("saturate", 4'hF, 4'hF);

        // A clear takes priority over a concurrent accepted branch.
        clr_cnt = 1'b1;
        issue(32'h0000_1000, 32'h0000_0002, 1'b1, 32'h0000_1008, 2);
        clr_cnt = 1'b0;
        repeat (3) step();
        chk_cnt("clr_prio", 4'd0, 4'd0);

        // Reset pulsed between edges mid-FLUSH clears outputs before the next edge.
        issue(32'h0000_2000, 32'h0000_0002, 1'b1, 32'h0000_2008, 1);
        chk_cnt("pre_reset", 4'd1, 4'd1);
        #5 reset = 1'b1;
        #1;
        chk("midrst_flush", {31'd0, flush}, 32'd0);
        chk("midrst_redirect", {31'd0, redirect}, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);
        chk_cnt("midrst", 4'd0, 4'd0);
        #1 reset = 1'b0;
        step();
        issue(32'h0040_0010, 32'h0000_0004, 1'b1, 32'h0040_0020, 2);
        repeat (3) step();
        chk_cnt("post_reset", 4'd1, 4'd1);
        chk("post_reset_pc_hold", redirect_pc, 32'h0040_0020);

        // Every queued expectation must have been consumed.
        step();
        chk("pending_redirects", exp_pc_q.size(), 32'd0);
        chk("pending_flushes", exp_fl_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2, number of cycles flush stays asserted per taken branch (legal 1..7).
REQ-002 Parameter CNT_W, default 16, width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ex_valid  input  1  EX stage holds a valid instruction.
REQ-006 ex_branch  input  1  EX instruction is a conditional branch.
REQ-007 cmp_s  input  1  condition result S from the ALU compare unit; 1 means taken.
REQ-008 ex_pc_plus4  input  32  PC+4 of the EX instruction.
REQ-009 ex_offset  input  32  sign-extended word offset (not yet shifted).
REQ-010 stall  input  1  pipeline hold; EX contents unchanged while 1.
REQ-011 clr_cnt  input  1  synchronous clear of statistics counters.
REQ-012 redirect  output  1  one-cycle pulse: fetch loads redirect_pc.
REQ-013 redirect_pc  output  32  branch target, valid when redirect=1.
REQ-014 flush  output  1  squash IF/ID and ID/EX contents.
REQ-015 br_cnt  output  CNT_W  resolved-branch count.
REQ-016 taken_cnt  output  CNT_W  taken-branch count.

Function
REQ-017 A branch is accepted on a rising edge where state=IDLE, ex_valid=1, ex_branch=1, stall=0.
REQ-018 Target SHALL be ex_pc_plus4 + (ex_offset << 2), 32-bit, carry discarded (wraps modulo 2^32).
REQ-019 States SHALL be IDLE and FLUSH, with a flush counter fcnt of 3 bits.
REQ-020 Accepted and cmp_s=1: next cycle redirect=1, redirect_pc=target, flush=1, state=FLUSH, fcnt=FLUSH_CYCLES-1.
REQ-021 Accepted and cmp_s=0: no redirect, no flush, state stays IDLE.
REQ-022 redirect SHALL be high for exactly one cycle per taken branch, regardless of stall.
REQ-023 redirect_pc SHALL hold its last value when redirect=0.
REQ-024 In FLUSH: flush=1; if stall=0 and fcnt=0 go IDLE (flush=0 next cycle), else if stall=0 decrement fcnt; stall=1 freezes fcnt.
REQ-025 Total flush high time with no stall SHALL be exactly FLUSH_CYCLES cycles, starting the cycle redirect is high.
REQ-026 ex_valid/ex_branch in FLUSH SHALL be ignored (wrong path): no acceptance, no count.
REQ-027 Branch presented with stall=1 in IDLE SHALL not be accepted; it is evaluated on the first edge with stall=0.
REQ-028 Non-branch or ex_valid=0 in IDLE: no state or counter change.
REQ-029 br_cnt increments on each acceptance; taken_cnt additionally when cmp_s=1.
REQ-030 Counters SHALL saturate at all-ones, never wrap.
REQ-031 clr_cnt=1 SHALL zero both counters next edge, priority over a same-cycle increment.
REQ-032 Latency: cmp_s sampled at accept edge; redirect/flush visible the following cycle (registered outputs, no combinational input-to-output path).

Reset
REQ-033 reset=1 SHALL immediately force state=IDLE, fcnt=0, redirect=0, redirect_pc=0, flush=0, br_cnt=0, taken_cnt=0.
REQ-034 Reset asserted during FLUSH SHALL drop flush and redirect without waiting for a clock edge; no pending redirect survives reset.
REQ-035 First acceptance possible on the first rising edge after reset deasserts.

Verification
REQ-036 pc_plus4=0x00400010, offset=0x00000004, cmp_s=1 -> next cycle redirect=1, redirect_pc=0x00400020, flush high 2 cycles, br_cnt=1, taken_cnt=1.
REQ-037 pc_plus4=0x00400010, offset=0xFFFFFFFC, cmp_s=0 -> redirect=0, flush=0, br_cnt=1, taken_cnt=0.
REQ-038 pc_plus4=0xFFFFFFF0, offset=0x00000008, taken -> redirect_pc=0x00000010 (wrap).
REQ-039 Taken branch, stall=1 for 3 cycles in FLUSH, branch held on ex inputs -> flush high 5 cycles, redirect 1 cycle, ignored branches not counted.
REQ-040 CNT_W=4, 17 taken branches -> both counters stick at 0xF; clr_cnt with concurrent branch -> both 0.
REQ-041 reset pulsed mid-FLUSH between edges -> flush=0 and redirect_pc=0 before next edge; subsequent branch resolves normally.
